// File: rtl/mem_pkg.sv
// mem_pkg: access-type and state encodings plus load-extension helpers
// shared by the memory arbiter controller and its arbiter.
package mem_pkg;
  localparam logic [1:0] TYPE_WORD = 2'b00;
  localparam logic [1:0] TYPE_HALF = 2'b01;
  localparam logic [1:0] TYPE_BYTE = 2'b10;
  localparam int TYPE_SIGNED_BIT = 2;
  localparam logic [31:0] IO_BASE_DEFAULT = 32'h30000;
  typedef enum logic [1:0] {IDLE, XFER, TAIL, RESP} state_e;
  // Index of the final byte of an access; the unused size code 11 acts as a byte.
  function automatic logic [1:0] last_byte(input logic [1:0] size);
    return size == TYPE_WORD ? 2'd3 : size == TYPE_HALF ? 2'd1 : 2'd0;
  endfunction
  function automatic logic [31:0] extend(input logic [31:0] d, input logic [2:0] t);
    logic s;
    s = t[TYPE_SIGNED_BIT];
    return (t[1:0] == TYPE_BYTE || t[1:0] == 2'b11) ? {{24{s & d[7]}}, d[7:0]} :
           t[1:0] == TYPE_HALF ? {{16{s & d[15]}}, d[15:0]} : d;
  endfunction
endpackage

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: one-hot grant among eligible ports, fixed priority or
// round-robin starting after the last accepted port.
module mem_rr_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ARB_MODE = 0,
  localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 accept,
  output logic [NUM_PORTS-1:0] grant,
  output logic [PW-1:0]        grant_idx
);
  logic [PW-1:0] last_grant;
  // Scan from the far end so the nearest candidate overwrites the rest.
  always_comb begin
    int k;
    grant = '0;
    grant_idx = '0;
    for (int o = NUM_PORTS - 1; o >= 0; o--) begin
      k = ARB_MODE == 1 ? (int'(last_grant) + 1 + o) % NUM_PORTS : o;
      if (req[k]) begin
        grant = '0;
        grant[k] = 1'b1;
        grant_idx = PW'(k);
      end
    end
  end
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) last_grant <= PW'(NUM_PORTS - 1);
    else if (accept) last_grant <= grant_idx;
  end
endmodule

// File: rtl/mem_arb_ctrl.sv
// mem_arb_ctrl: arbitrates multi-port load/store requests onto a byte-wide
// memory with a one-cycle read latency, one transfer at a time.
module mem_arb_ctrl
  import mem_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ARB_MODE = 0,
  parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT,
  localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic [7:0]             mem_read,
  output logic [7:0]             mem_write,
  output logic [31:0]            mem_addr,
  output logic                   r_nw_out,
  input  logic                   io_buffer_full,
  input  logic [NUM_PORTS-1:0]   req_valid_in,
  output logic [NUM_PORTS-1:0]   req_ready_out,
  input  logic [32*NUM_PORTS-1:0] req_addr_in,
  input  logic [32*NUM_PORTS-1:0] req_data_in,
  input  logic [NUM_PORTS-1:0]   req_r_nw_in,
  input  logic [3*NUM_PORTS-1:0] req_type_in,
  output logic [NUM_PORTS-1:0]   resp_valid_out,
  output logic [31:0]            resp_data_out
);
  state_e state;
  logic [1:0] cnt;
  logic [31:0] addr, data, rd_full;
  logic r_nw, accept, last;
  logic [2:0] typ;
  logic [PW-1:0] port, grant_idx;
  logic [NUM_PORTS-1:0] elig, grant;
  // A store into I/O space must wait while the I/O sink cannot take it.
  always_comb begin
    elig = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      elig[p] = req_valid_in[p] &&
                !(io_buffer_full && !req_r_nw_in[p] && req_addr_in[32*p +: 32] >= IO_BASE);
  end
  mem_rr_arbiter #(.NUM_PORTS(NUM_PORTS), .ARB_MODE(ARB_MODE)) u_arb (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .req      (elig),
    .accept   (accept),
    .grant    (grant),
    .grant_idx(grant_idx)
  );
  assign req_ready_out = (rst_in && rdy_in && state == IDLE) ? grant : '0;
  assign accept = |req_ready_out;
  assign resp_valid_out = (rdy_in && state == RESP) ? NUM_PORTS'(1) << port : '0;
  assign last = cnt == last_byte(typ[1:0]);
  assign mem_addr = state == XFER ? addr + 32'(cnt) : '0;
  assign r_nw_out = state == XFER ? r_nw : 1'b1;
  assign mem_write = (state == XFER && !r_nw) ? data[{cnt, 3'b000} +: 8] : '0;
  // The final read byte arrives during TAIL and is folded in without a register.
  always_comb begin
    rd_full = data;
    rd_full[{last_byte(typ[1:0]), 3'b000} +: 8] = mem_read;
  end
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= IDLE;
      cnt <= '0;
      addr <= '0;
      data <= '0;
      r_nw <= 1'b0;
      typ <= '0;
      port <= '0;
      resp_data_out <= '0;
    end else if (rdy_in) begin
      case (state)
        IDLE: if (accept) begin
          state <= XFER;
          cnt <= '0;
          addr <= req_addr_in[32*grant_idx +: 32];
          data <= req_data_in[32*grant_idx +: 32];
          r_nw <= req_r_nw_in[grant_idx];
          typ <= req_type_in[3*grant_idx +: 3];
          port <= grant_idx;
        end
        XFER: begin
          cnt <= cnt + 2'd1;
          if (r_nw && cnt != 2'd0) data[{cnt - 2'd1, 3'b000} +: 8] <= mem_read;
          if (last) state <= r_nw ? TAIL : RESP;
          if (last && !r_nw) resp_data_out <= '0;
        end
        TAIL: begin
          state <= RESP;
          resp_data_out <= extend(rd_full, typ);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_arb_ctrl.md
MEM_ARB_CTRL -- requirements
Module: mem_arb_ctrl

Interface
REQ-001 SHALL take parameter NUM_PORTS, default 2: number of requester ports; port 0 has highest fixed priority.
REQ-002 SHALL take parameter ARB_MODE, default 0: 0 = fixed priority, 1 = round-robin.
REQ-003 SHALL take parameter IO_BASE, default 32'h30000: addresses >= IO_BASE are I/O space.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with ports named as follows.
- clk_in  input  1  clock
- rst_in  input  1  asynchronous active-low reset
- rdy_in  input  1  global enable; 0 freezes the block
- mem_read  input  8  memory read byte
- mem_write  output  8  memory write byte
- mem_addr  output  32  memory byte address
- r_nw_out  output  1  1 = read, 0 = write
- io_buffer_full  input  1  I/O sink full
- req_valid_in  input  NUM_PORTS  per-port request valid
- req_ready_out  output  NUM_PORTS  per-port accept strobe
- req_addr_in  input  32*NUM_PORTS  per-port address, packed with port p at bits [32p+31:32p]
- req_data_in  input  32*NUM_PORTS  per-port write data, packed
- req_r_nw_in  input  NUM_PORTS  per-port read/write select
- req_type_in  input  3*NUM_PORTS  per-port type: [1:0] 00 word, 01 half, 10 byte; [2] 1 = signed
- resp_valid_out  output  NUM_PORTS  one-hot completion pulse
- resp_data_out  output  32  load result, extended to 32 bits

Function
REQ-005 SHALL complete one request at a time; a request is accepted when req_valid_in[p] and req_ready_out[p] are both 1 on a rising edge.
REQ-006 SHALL assert req_ready_out for exactly one port, and only in IDLE, while rdy_in = 1.
REQ-007 SHALL exclude from arbitration any port whose request is a write to I/O space while io_buffer_full = 1.
REQ-008 In ARB_MODE 0, SHALL grant the lowest-index eligible port.
REQ-009 In ARB_MODE 1, SHALL grant the first eligible port at or after (last_grant + 1) mod NUM_PORTS, and update last_grant only on accept.
REQ-010 SHALL latch the address, data, r_nw, type and port index on accept.
REQ-011 SHALL set byte count n to 4, 2 or 1 for word, half or byte; type [1:0] = 11 SHALL be treated as byte.
REQ-012 SHALL implement states IDLE, XFER, TAIL and RESP.
- IDLE -> XFER on accept, with cnt = 0.
- XFER drives mem_addr = addr + cnt, r_nw_out = latched r_nw, and mem_write = byte cnt of the data (0 on reads).
- XFER: cnt increments each cycle; after cnt = n-1, reads go to TAIL and writes go to RESP.
- TAIL drives mem_addr = 0, r_nw_out = 1 and captures the last read byte.
- RESP pulses resp_valid_out[port] for one cycle, then returns to IDLE.
REQ-013 On reads, SHALL capture mem_read into byte (cnt-1) in each XFER cycle with cnt >= 1, and into byte n-1 in TAIL.
REQ-014 SHALL produce resp_valid n+2 cycles after accept for reads and n+1 cycles after accept for writes.
REQ-015 SHALL hold resp_data_out stable from RESP until the next RESP.
- Signed types: sign-extend from bit 8n-1.
- Unsigned types: zero-fill above bit 8n-1.
- Writes: 0.
REQ-016 SHALL drive mem_addr = 0, r_nw_out = 1 and mem_write = 0 in IDLE, TAIL (except its capture) and RESP.
REQ-017 With rdy_in = 0, SHALL freeze all registers and outputs, and hold req_ready_out and resp_valid_out at 0.
REQ-018 SHALL not let a change in io_buffer_full during XFER alter an accepted transfer.
REQ-019 SHALL not accept a new request in RESP; the earliest next accept is the cycle after RESP.

Reset
REQ-020 Asserting rst_in low, at any time including mid-transfer, SHALL immediately force:
- state = IDLE, cnt = 0, last_grant = NUM_PORTS-1;
- all latched request fields = 0, resp_data_out = 0;
- mem_addr = 0, mem_write = 0, r_nw_out = 1;
- req_ready_out = 0, resp_valid_out = 0.
REQ-021 An interrupted transfer SHALL be dropped, with no resp_valid_out pulse.

Structure
REQ-022 SHALL place the type encodings (word, half, byte, signed bit), the state encodings and IO_BASE in the shared package mem_pkg.
REQ-023 SHALL implement arbitration in one sub-module, mem_rr_arbiter, parametrised by NUM_PORTS and ARB_MODE, that outputs a one-hot grant.

Verification
REQ-024 The bench SHALL cover:
- Port 0 LW at 0x100, memory bytes 11 22 33 44 -> resp_valid_out[0] 6 cycles after accept, resp_data_out = 0x44332211.
- Port 1 LB at 0x200, byte 0x80 -> resp_data_out = 0xFFFFFF80; LBU of the same byte -> 0x00000080.
- ARB_MODE 1, both ports requesting continuously -> grants alternate 0,1,0,1; ARB_MODE 0 -> port 0 always wins.
- SB 0x41 to 0x30000 with io_buffer_full = 1 -> no accept; release full -> write beat mem_addr = 0x30000, mem_write = 0x41, resp 2 cycles after accept.
- SW 0xDEADBEEF to 0x10 -> beats EF BE AD DE at 0x10..0x13 with r_nw_out = 0; rdy_in low for 2 mid-beats -> outputs held and the sequence resumes intact.
- rst_in low during XFER of an LW -> outputs reset at once and no resp pulse; the next request completes normally.
